cmd_frame_decoder: RTL
======================

# cmd_frame_decoder

Front-end command decoder between the UART receiver and the FIFO/SD command controller. It hunts for a framed header in the received byte stream and issues a one-cycle command code plus 16-bit length to the controller. It then ignores payload bytes, which the controller consumes itself. When the controller reports completion, it returns the `fe_done` acknowledge that releases the controller back to idle.

## Interface
- `TIMEOUT_CYCLES`, default 50000: maximum clk cycles allowed between consecutive header bytes (1 ms at 50 MHz).
- `SOF_BYTE`, default 8'hA5: start-of-frame marker.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `rst` input 1: reset, synchronous, active-high.
- `rx_data` input 8: received UART byte, valid when `rx_valid`.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `fifo_busy` input 1: controller not in idle.
- `fifo_done` input 1: controller in done state; held until `fe_done` is seen.
- `cmd` output 8: command code; nonzero for exactly one cycle per issued frame, else 8'h00.
- `rx_cnt` output 16: frame length; stable from the `cmd` cycle until the `fe_done` cycle.
- `fe_done` output 1: one-cycle acknowledge to the controller.
- `frame_err` output 1: one-cycle pulse on a dropped frame.
- `err_code` output 2: cause of the last error; held until the next error. 0 none, 1 timeout, 2 bad cmd, 3 checksum.

## Operation
- Frame layout: `SOF_BYTE`, CMD, LEN_H, LEN_L, then CHK if configured, then payload.
- Payload is not handled here.
- States and transitions:
  - HUNT: bytes other than `SOF_BYTE` are discarded. SOF → CMD.
  - CMD: store the byte → LEN_H.
  - LEN_H: store the byte → LEN_L.
  - LEN_L: store the byte → CHK if configured, else → ISSUE.
  - CHK: compare the byte → ISSUE on match. On mismatch → HUNT with error code 3.
  - ISSUE → BUSY, see "Issue" below.
  - BUSY → ACK, see "Completion" below.
  - ACK → HUNT.
- Valid CMD codes are 8'h01 (UART loopback), 8'h02 (SD init) and 8'h03 (SD read).
  - Any other code is checked on entering ISSUE: → HUNT with error code 2, no `cmd` pulse.
  - For 8'h03, `rx_cnt` is forced to 0.
- Issue: when `fifo_busy` is 0, drive `cmd` for one cycle and load `rx_cnt` = {LEN_H, LEN_L}, then → BUSY. While `fifo_busy` is 1, wait in ISSUE with no timeout.
- Completion: in BUSY, all `rx_valid` strobes are ignored, including SOF values inside the payload. On `fifo_done` = 1 → ACK.
- In ACK, `fe_done` = 1 for one cycle, then → HUNT with `rx_cnt` cleared to 0.
- Timeout: a cycle counter runs in CMD, LEN_H, LEN_L and CHK, and restarts on every `rx_valid`. Reaching `TIMEOUT_CYCLES` → HUNT with error code 1.
- Every error sets `frame_err` for one cycle and updates `err_code`.
- LEN = 0 is legal and is issued normally.

## Timing
- Reset values: `cmd` 0, `rx_cnt` 0, `fe_done` 0, `frame_err` 0, `err_code` 0, state HUNT, timeout counter 0.
- Reset mid-frame or mid-BUSY returns to HUNT immediately, with no `fe_done` and no `frame_err`.
- All outputs are registered.
- Issue latency: last header byte strobe at edge N gives `cmd` high during the cycle after edge N+1, provided `fifo_busy` was 0 at edge N+1.
- Acknowledge latency: `fifo_done` sampled high at edge M gives `fe_done` high during the cycle after edge M+1.
- Error pulse latency: the error is detected at edge K (CHK byte, ISSUE entry or timeout) and `frame_err` is high during the cycle after edge K+1.
- `rx_valid` in the same cycle as timeout expiry: the byte wins, the counter restarts and no error is raised.
- Timeout counter width is clog2(`TIMEOUT_CYCLES`+1). It saturates and never wraps.

## Configuration
- `CMD_CHECKSUM_EN` defined:
  - CHK state is present; the expected CHK is CMD ^ LEN_H ^ LEN_L.
  - The minimum issue latency counts from the CHK strobe.
- `CMD_CHECKSUM_EN` undefined:
  - The CHK state is removed, LEN_L → ISSUE directly.
  - `err_code` 3 is never produced.

## Structure
- Shared package `fe_pkg` holds:
  - state encoding;
  - `SOF_BYTE` default;
  - command constants CMD_LOOP = 8'h01, CMD_SD_INIT = 8'h02, CMD_SD_READ = 8'h03;
  - error constants ERR_NONE, ERR_TIMEOUT, ERR_BADCMD, ERR_CHKSUM.
- One sub-module, `fe_timeout`: a restartable saturating counter.
  - Inputs: `clk`, `rst`, `run`, `restart`.
  - Output: `expired`.

## Test plan
- Frame A5 01 00 03 (plus CHK 02 when configured) with `fifo_busy` = 0 → one `cmd` = 01 pulse and `rx_cnt` = 3. Three payload bytes including A5 cause no reaction. Raising `fifo_done` → one `fe_done` pulse, then HUNT.
- Frame A5 07 00 00 → no `cmd` pulse; `frame_err` pulse; `err_code` = 2.
- A5 01, then no byte for 50000 cycles → `frame_err` pulse; `err_code` = 1. A byte arriving exactly at expiry → no error.
- `CMD_CHECKSUM_EN` defined, frame A5 02 01 00 with CHK FF → `err_code` = 3, no `cmd`. With CHK 03 → `cmd` = 02 pulse and `rx_cnt` = 16'h0100.
- Frame A5 03 12 34 issued while `fifo_busy` = 1 for 10 cycles → `cmd` = 03 pulse the cycle after `fifo_busy` falls; `rx_cnt` = 0.
- `rst` asserted during LEN_H, then a new frame A5 01 00 01 → issued normally. Bytes 55 55 before SOF are ignored.

Source files
------------

// File: rtl/fe_pkg.sv
// Shared definitions for the command frame decoder: FSM encoding, framing constants
// and error causes. Used by cmd_frame_decoder and fe_timeout.
package fe_pkg;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LEN_H = 3'd2,
        ST_LEN_L = 3'd3,
        ST_CHK   = 3'd4,
        ST_ISSUE = 3'd5,
        ST_BUSY  = 3'd6,
        ST_ACK   = 3'd7
    } fe_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    localparam logic [7:0] CMD_LOOP    = 8'h01;
    localparam logic [7:0] CMD_SD_INIT = 8'h02;
    localparam logic [7:0] CMD_SD_READ = 8'h03;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_BADCMD  = 2'd2;
    localparam logic [1:0] ERR_CHKSUM  = 2'd3;

    function automatic logic cmd_is_valid(input logic [7:0] code);
        return (code == CMD_LOOP) || (code == CMD_SD_INIT) || (code == CMD_SD_READ);
    endfunction

endpackage

// File: rtl/fe_timeout.sv
// Restartable saturating inter-byte counter. Held at zero while not running;
// expired stays high once LIMIT cycles have elapsed without a restart.
module fe_timeout #(
    parameter int LIMIT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || !run || restart) begin
            count_reg <= '0;
        end else if (count_reg != LIMIT_W) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LIMIT_W);

endmodule

// File: rtl/cmd_frame_decoder.sv
// Hunts for SOF/CMD/LEN_H/LEN_L[/CHK] headers, issues one-cycle commands to the
// FIFO/SD controller and acknowledges completion. CHK byte enabled by CMD_CHECKSUM_EN.
module cmd_frame_decoder
    import fe_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        fifo_busy,
    input  logic        fifo_done,
    output logic [7:0]  cmd,
    output logic [15:0] rx_cnt,
    output logic        fe_done,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    fe_state_t   state_reg, state_next;
    logic [7:0]  cmd_byte_reg, len_h_reg, len_l_reg;
    logic [7:0]  cmd_reg, cmd_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic        fe_done_reg, fe_done_next;
    logic        frame_err_reg;
    logic [1:0]  err_code_reg;
    logic        err_pend_reg, err_pend_next;
    logic [1:0]  err_cause_reg, err_cause_next;

    logic expired, run, cmd_bad, chk_bad, hdr_done, timeout_hit;

    assign run = (state_reg == ST_CMD) || (state_reg == ST_LEN_H) ||
                 (state_reg == ST_LEN_L) || (state_reg == ST_CHK);
    assign cmd_bad     = !cmd_is_valid(cmd_byte_reg);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_hit = run && expired && !rx_valid;

`ifdef CMD_CHECKSUM_EN
    assign hdr_done = (state_reg == ST_CHK) && rx_valid;
    assign chk_bad  = hdr_done && (rx_data != (cmd_byte_reg ^ len_h_reg ^ len_l_reg));
`else
    assign hdr_done = (state_reg == ST_LEN_L) && rx_valid;
    assign chk_bad  = 1'b0;
`endif

    fe_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .restart (rx_valid),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_HUNT: begin
                if (rx_valid && (rx_data == SOF_BYTE)) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (timeout_hit) begin
                    state_next = ST_HUNT;
                end else if (rx_valid) begin
                    state_next = ST_LEN_H;
                end
            end
            ST_LEN_H: begin
                if (timeout_hit) begin
                    state_next = ST_HUNT;
                end else if (rx_valid) begin
                    state_next = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (timeout_hit) begin
                    state_next = ST_HUNT;
                end else if (rx_valid) begin
`ifdef CMD_CHECKSUM_EN
                    state_next = ST_CHK;
`else
                    state_next = cmd_bad ? ST_HUNT : ST_ISSUE;
`endif
                end
            end
`ifdef CMD_CHECKSUM_EN
            ST_CHK: begin
                if (timeout_hit) begin
                    state_next = ST_HUNT;
                end else if (rx_valid) begin
                    state_next = (chk_bad || cmd_bad) ? ST_HUNT : ST_ISSUE;
                end
            end
`endif
            ST_ISSUE: begin
                if (!fifo_busy) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (fifo_done) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_HUNT;
            default: state_next = ST_HUNT;
        endcase
    end

    // Errors are latched as pending and published one cycle later, so every
    // cause shares the same detect-to-pulse latency.
    always_comb begin
        cmd_next       = 8'h00;
        rx_cnt_next    = rx_cnt_reg;
        fe_done_next   = 1'b0;
        err_pend_next  = 1'b0;
        err_cause_next = err_cause_reg;

        if ((state_reg == ST_ISSUE) && !fifo_busy) begin
            cmd_next    = cmd_byte_reg;
            rx_cnt_next = (cmd_byte_reg == CMD_SD_READ) ? 16'h0000 : {len_h_reg, len_l_reg};
        end
        if (state_reg == ST_ACK) begin
            fe_done_next = 1'b1;
        end
        // Length stays visible through the acknowledge cycle, cleared right after.
        if (fe_done_reg) begin
            rx_cnt_next = 16'h0000;
        end

        if (timeout_hit) begin
            err_pend_next  = 1'b1;
            err_cause_next = ERR_TIMEOUT;
        end else if (chk_bad) begin
            err_pend_next  = 1'b1;
            err_cause_next = ERR_CHKSUM;
        end else if (hdr_done && cmd_bad) begin
            err_pend_next  = 1'b1;
            err_cause_next = ERR_BADCMD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_byte_reg  <= 8'h00;
            len_h_reg     <= 8'h00;
            len_l_reg     <= 8'h00;
            cmd_reg       <= 8'h00;
            rx_cnt_reg    <= 16'h0000;
            fe_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
            err_pend_reg  <= 1'b0;
            err_cause_reg <= ERR_NONE;
        end else begin
            if (rx_valid) begin
                case (state_reg)
                    ST_CMD:   cmd_byte_reg <= rx_data;
                    ST_LEN_H: len_h_reg    <= rx_data;
                    ST_LEN_L: len_l_reg    <= rx_data;
                    default:  ;
                endcase
            end
            cmd_reg       <= cmd_next;
            rx_cnt_reg    <= rx_cnt_next;
            fe_done_reg   <= fe_done_next;
            err_pend_reg  <= err_pend_next;
            err_cause_reg <= err_cause_next;
            frame_err_reg <= err_pend_reg;
            if (err_pend_reg) begin
                err_code_reg <= err_cause_reg;
            end
        end
    end

    assign cmd       = cmd_reg;
    assign rx_cnt    = rx_cnt_reg;
    assign fe_done   = fe_done_reg;
    assign frame_err = frame_err_reg;
    assign err_code  = err_code_reg;

endmodule
